// File: rtl/aes_key_pkg.sv
// Shared types and sizing for the AES key-expansion sequencer and its helpers.
package aes_key_pkg;

    localparam int unsigned AES_DATA_WIDTH = 128;
    localparam int unsigned AES_NUM_ROUNDS = 10;
    localparam int unsigned RC_IDX_W       = $clog2(AES_NUM_ROUNDS);
    localparam int unsigned RK_IDX_W       = $clog2(AES_NUM_ROUNDS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT, EXPAND} kexp_state_t;

endpackage

// File: rtl/aes_kexp_round_cnt.sv
// Round counter for the key-expansion sequencer: clear, saturating increment,
// terminal-count flag when the last round key index is reached.
module aes_kexp_round_cnt
    import aes_key_pkg::*;
#(
    parameter int unsigned MAX_CNT = AES_NUM_ROUNDS,
    parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CNT);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes_key_exp_ctrl.sv
// Sequencer in front of the AES key-expansion datapath: captures a cipher key,
// steps the datapath round by round and presents each round key on a valid/ready port.
module aes_key_exp_ctrl
    import aes_key_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AES_DATA_WIDTH,
    parameter int unsigned RC_WIDTH   = AES_NUM_ROUNDS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          key_in,
    input  logic                           key_valid,
    output logic                           key_ready,
    output logic [DATA_WIDTH-1:0]          key_vector,
    output logic                           key_MUX1,
    output logic                           key_MUX2,
    output logic [$clog2(RC_WIDTH)-1:0]    RC_sig,
    output logic                           FF1_enable,
    output logic                           rk_valid,
    input  logic                           rk_ready,
    output logic [$clog2(RC_WIDTH+1)-1:0]  rk_index,
    output logic                           rk_last,
    output logic                           busy
);

    localparam int unsigned RCW = $clog2(RC_WIDTH);
    localparam int unsigned RKW = $clog2(RC_WIDTH + 1);

    kexp_state_t    state;
    logic [RKW-1:0] r;
    logic           r_tc;
    logic           r_clr;
    logic           r_inc;

    assign r_clr = (state == IDLE) && key_valid;
    assign r_inc = (state == PRESENT) && rk_ready;

    aes_kexp_round_cnt #(
        .MAX_CNT (RC_WIDTH),
        .CNT_W   (RKW)
    ) u_round_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (r_clr),
        .inc   (r_inc),
        .cnt   (r),
        .tc    (r_tc)
    );

    // Outputs are registered alongside the state; the counter already holds the
    // index of the next key on entry to PRESENT, and the index just left on entry to EXPAND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_vector <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            key_MUX1   <= 1'b0;
            key_MUX2   <= 1'b0;
            RC_sig     <= '0;
            FF1_enable <= 1'b0;
            rk_valid   <= 1'b0;
            rk_index   <= '0;
            rk_last    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        state      <= LOAD;
                        key_vector <= key_in;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        key_MUX1   <= 1'b1;
                        FF1_enable <= 1'b1;
                    end
                end
                LOAD, EXPAND: begin
                    state      <= PRESENT;
                    key_MUX1   <= 1'b0;
                    FF1_enable <= 1'b0;
                    RC_sig     <= '0;
                    rk_valid   <= 1'b1;
                    rk_index   <= r;
                    rk_last    <= r_tc;
                    key_MUX2   <= (r == '0);
                end
                PRESENT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        rk_last  <= 1'b0;
                        key_MUX2 <= 1'b0;
                        if (r_tc) begin
                            state     <= IDLE;
                            key_ready <= 1'b1;
                            busy      <= 1'b0;
                            rk_index  <= '0;
                        end else begin
                            state      <= EXPAND;
                            FF1_enable <= 1'b1;
                            RC_sig     <= r[RCW-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_exp_ctrl.sv
// Bench for aes_key_exp_ctrl: an event-timing reference model plus an AES-128
// key-schedule datapath model driven by the DUT controls.
module tb_aes_key_exp_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_vector;
    logic         key_MUX1;
    logic         key_MUX2;
    logic [3:0]   RC_sig;
    logic         FF1_enable;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic         rk_last;
    logic         busy;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    aes_key_exp_ctrl #(.DATA_WIDTH(128), .RC_WIDTH(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_vector (key_vector),
        .key_MUX1   (key_MUX1),
        .key_MUX2   (key_MUX2),
        .RC_sig     (RC_sig),
        .FF1_enable (FF1_enable),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_index   (rk_index),
        .rk_last    (rk_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 key schedule reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] s = b;
        logic [7:0] r = b;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        sbox[0] = affine(8'h00);
        for (int x = 1; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox[x] = affine(inv);
        end
    endtask

    function automatic logic [127:0] next_round(input logic [127:0] k, input int rc_idx);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < rc_idx; i++) rc = xtime(rc);
        {w0, w1, w2, w3} = k;
        t = {w3[23:0], w3[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] rk_of(input logic [127:0] k, input int n);
        for (int i = 0; i < n; i++) k = next_round(k, i);
        return k;
    endfunction

    // Datapath stand-in steered only by the DUT control outputs.
    logic [127:0] dp_reg;
    logic [127:0] dp_out;
    always @(posedge clk)
        if (FF1_enable) dp_reg <= key_MUX1 ? key_vector : next_round(dp_reg, int'(RC_sig));
    assign dp_out = key_MUX2 ? key_vector : dp_reg;

    // ---------------- Event-timing reference model ----------------
    // m_age counts cycles since the last accepted key or round-key handshake.
    logic         m_busy;
    int           m_idx;
    int           m_age;
    logic         m_from_key;
    logic [127:0] m_key;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_idx <= 0; m_age <= 0; m_from_key <= 1'b0; m_key <= '0;
        end else if (!m_busy) begin
            if (key_valid) begin
                m_busy <= 1'b1; m_idx <= 0; m_age <= 1; m_from_key <= 1'b1; m_key <= key_in;
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (rk_ready) begin
            if (m_idx == 10) m_busy <= 1'b0;
            else begin
                m_idx <= m_idx + 1; m_age <= 1; m_from_key <= 1'b0;
            end
        end
    end

    // {key_ready, busy, rk_valid, rk_last, key_MUX1, key_MUX2, FF1_enable, RC_sig}
    logic [10:0] ctrl_obs, ctrl_exp;
    logic        exp_valid;
    assign ctrl_obs = {key_ready, busy, rk_valid, rk_last, key_MUX1, key_MUX2, FF1_enable, RC_sig};

    always_comb begin
        ctrl_exp  = 11'h400;
        exp_valid = 1'b0;
        if (m_busy) begin
            if (m_age == 1) begin
                ctrl_exp = {4'b0100, m_from_key, 1'b0, 1'b1, m_from_key ? 4'd0 : 4'(m_idx - 1)};
            end else begin
                ctrl_exp  = {3'b011, (m_idx == 10), 1'b0, (m_idx == 0), 1'b0, 4'd0};
                exp_valid = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; key_valid = 1'b0; rk_ready = 1'b0; key_in = rand128();
        repeat (3) tick();
        vectors++;
        if (ctrl_obs !== 11'h400) begin fails++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_obs, 11'h400); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (ctrl_obs !== 11'h400 || rk_index !== 4'd0 || key_vector !== '0) begin
                fails++;
                $display("FAIL idle_ctrl cyc=%0d got=%b idx=%0d kv=%h exp=%b idx=0 kv=0", cyc, ctrl_obs, rk_index, key_vector, 11'h400);
            end
        end
    endtask

    task automatic test_full_schedule();
        int t_acc, first_v = -1, last_c = -1, ready_c = -1;
        key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c; key_valid = 1'b1; rk_ready = 1'b1;
        vectors++;
        if (key_ready !== 1'b1) begin fails++; $display("FAIL full_key_ready got=%b exp=1", key_ready); end
        t_acc = cyc;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vectors++;
            if (ctrl_obs !== ctrl_exp) begin fails++; $display("FAIL full_ctrl cyc=%0d got=%b exp=%b", cyc, ctrl_obs, ctrl_exp); end
            if (exp_valid) begin
                vectors++;
                if (rk_index !== 4'(m_idx) || dp_out !== rk_of(m_key, m_idx)) begin
                    fails++; $display("FAIL full_rk idx=%0d rk=%h exp idx=%0d rk=%h", rk_index, dp_out, m_idx, rk_of(m_key, m_idx));
                end
            end
            if (rk_valid && first_v < 0) first_v = cyc;
            if (rk_last) begin
                last_c = cyc;
                vectors++;
                if (dp_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
                    fails++; $display("FAIL full_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", dp_out);
                end
            end
            if (key_ready) begin ready_c = cyc; break; end
            tick();
        end
        vectors++;
        if (first_v != t_acc + 2) begin fails++; $display("FAIL full_first_valid got=%0d exp=%0d", first_v, t_acc + 2); end
        vectors++;
        if (last_c != t_acc + 22) begin fails++; $display("FAIL full_rk_last got=%0d exp=%0d", last_c, t_acc + 22); end
        vectors++;
        if (ready_c != t_acc + 23) begin fails++; $display("FAIL full_key_ready_back got=%0d exp=%0d", ready_c, t_acc + 23); end
    endtask

    task automatic test_stall();
        int stall_n = 0, n_rc4 = 0;
        logic done = 1'b0;
        key_in = rand128(); key_valid = 1'b1; rk_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            vectors++;
            if (ctrl_obs !== ctrl_exp) begin fails++; $display("FAIL stall_ctrl cyc=%0d got=%b exp=%b", cyc, ctrl_obs, ctrl_exp); end
            if (exp_valid) begin
                vectors++;
                if (rk_index !== 4'(m_idx) || dp_out !== rk_of(m_key, m_idx)) begin
                    fails++; $display("FAIL stall_rk idx=%0d rk=%h exp idx=%0d rk=%h", rk_index, dp_out, m_idx, rk_of(m_key, m_idx));
                end
            end
            if (!rk_ready) begin
                vectors++;
                if (rk_index !== 4'd4 || FF1_enable !== 1'b0 || RC_sig !== 4'd0) begin
                    fails++; $display("FAIL stall_hold idx=%0d ff1=%b rc=%0d exp idx=4 ff1=0 rc=0", rk_index, FF1_enable, RC_sig);
                end
            end
            if (FF1_enable && !key_MUX1 && RC_sig == 4'd4) n_rc4++;
            if (key_ready) begin done = 1'b1; break; end
            if (rk_valid && rk_index == 4'd4 && stall_n < 5) begin rk_ready = 1'b0; stall_n++; end
            else rk_ready = 1'b1;
            tick();
        end
        rk_ready = 1'b1;
        vectors++;
        if (!done || stall_n != 5 || n_rc4 != 1) begin
            fails++; $display("FAIL stall_summary done=%b stalls=%0d rc4_expands=%0d exp done=1 stalls=5 rc4_expands=1", done, stall_n, n_rc4);
        end
    endtask

    task automatic test_ignored_inputs();
        logic [127:0] k = rand128();
        logic done = 1'b0;
        key_in = k; key_valid = 1'b1; rk_ready = 1'b0;
        tick();
        for (int i = 0; i < 200; i++) begin
            vectors++;
            if (ctrl_obs !== ctrl_exp) begin fails++; $display("FAIL ign_ctrl cyc=%0d got=%b exp=%b", cyc, ctrl_obs, ctrl_exp); end
            vectors++;
            if (key_vector !== k) begin fails++; $display("FAIL ign_key_vector got=%h exp=%h", key_vector, k); end
            if (exp_valid) begin
                vectors++;
                if (rk_index !== 4'(m_idx) || dp_out !== rk_of(k, m_idx)) begin
                    fails++; $display("FAIL ign_rk idx=%0d rk=%h exp idx=%0d rk=%h", rk_index, dp_out, m_idx, rk_of(k, m_idx));
                end
            end
            if (!busy) begin done = 1'b1; key_valid = 1'b0; break; end
            key_valid = $urandom_range(0, 1) == 1;
            key_in    = rand128();
            rk_ready  = $urandom_range(0, 1) == 1;
            tick();
        end
        key_valid = 1'b0; rk_ready = 1'b1;
        vectors++;
        if (!done) begin fails++; $display("FAIL ign_timeout busy=%b exp=0", busy); end
    endtask

    task automatic test_midrun_reset();
        int t_acc, first_v = -1;
        logic hit = 1'b0, done = 1'b0;
        key_in = rand128(); key_valid = 1'b1; rk_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vectors++;
            if (ctrl_obs !== ctrl_exp) begin fails++; $display("FAIL mrst_ctrl cyc=%0d got=%b exp=%b", cyc, ctrl_obs, ctrl_exp); end
            if (FF1_enable && !key_MUX1 && RC_sig == 4'd5) begin hit = 1'b1; break; end
            tick();
        end
        vectors++;
        if (!hit) begin fails++; $display("FAIL mrst_reach_expand6 got=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ctrl_obs !== 11'h400 || rk_index !== 4'd0 || key_vector !== '0) begin
            fails++; $display("FAIL mrst_async got=%b idx=%0d kv=%h exp=%b idx=0 kv=0", ctrl_obs, rk_index, key_vector, 11'h400);
        end
        tick();
        rst_n = 1'b1;
        key_in = rand128(); key_valid = 1'b1;
        t_acc = cyc;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vectors++;
            if (ctrl_obs !== ctrl_exp) begin fails++; $display("FAIL mrst_ctrl2 cyc=%0d got=%b exp=%b", cyc, ctrl_obs, ctrl_exp); end
            if (exp_valid) begin
                vectors++;
                if (rk_index !== 4'(m_idx) || dp_out !== rk_of(m_key, m_idx)) begin
                    fails++; $display("FAIL mrst_rk idx=%0d rk=%h exp idx=%0d rk=%h", rk_index, dp_out, m_idx, rk_of(m_key, m_idx));
                end
            end
            if (rk_valid && first_v < 0) first_v = cyc;
            if (key_ready) begin done = 1'b1; break; end
            tick();
        end
        vectors++;
        if (!done || first_v != t_acc + 2) begin
            fails++; $display("FAIL mrst_restart done=%b first_valid=%0d exp done=1 first_valid=%0d", done, first_v, t_acc + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka = rand128();
        logic [127:0] kb = rand128();
        int last_c = -1, acc_c = -1, first2 = -1;
        key_in = ka; key_valid = 1'b1; rk_ready = 1'b1;
        tick();
        key_in = kb;
        for (int i = 0; i < 60; i++) begin
            vectors++;
            if (ctrl_obs !== ctrl_exp) begin fails++; $display("FAIL b2b_ctrl cyc=%0d got=%b exp=%b", cyc, ctrl_obs, ctrl_exp); end
            vectors++;
            if (key_vector !== m_key) begin fails++; $display("FAIL b2b_key_vector got=%h exp=%h", key_vector, m_key); end
            if (exp_valid) begin
                vectors++;
                if (rk_index !== 4'(m_idx) || dp_out !== rk_of(m_key, m_idx)) begin
                    fails++; $display("FAIL b2b_rk idx=%0d rk=%h exp idx=%0d rk=%h", rk_index, dp_out, m_idx, rk_of(m_key, m_idx));
                end
            end
            if (acc_c >= 0 && rk_valid) begin first2 = cyc; break; end
            if (rk_last && rk_ready) last_c = cyc;
            if (key_ready && last_c >= 0 && acc_c < 0) acc_c = cyc;
            if (acc_c >= 0 && acc_c != cyc) key_valid = 1'b0;
            tick();
            if (acc_c >= 0) key_valid = 1'b0;
        end
        key_valid = 1'b0;
        vectors++;
        if (last_c < 0 || acc_c != last_c + 1) begin fails++; $display("FAIL b2b_accept got=%0d exp=%0d", acc_c, last_c + 1); end
        vectors++;
        if (first2 != acc_c + 2 || rk_index !== 4'd0 || key_vector !== kb) begin
            fails++; $display("FAIL b2b_second_idx0 cyc=%0d idx=%0d kv=%h exp cyc=%0d idx=0 kv=%h", first2, rk_index, key_vector, acc_c + 2, kb);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t limit=500000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; rk_ready = 1'b0; key_in = '0;
        build_sbox();
        test_reset();
        test_full_schedule();
        test_stall();
        test_ignored_inputs();
        test_midrun_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
